// File: rtl/pipelined_shifter_if.sv
// Valid/ready bus of the pipelined shift unit: one operation in, one tagged result out.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SA_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SA_W-1:0]  in_sa;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_sa, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_sa, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR with carry-out, zero and illegal flags.
// log2(WIDTH) shift levels are split over PIPE register stages under one global stall.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_shifter_if.slave  bus
);
    localparam int SA_W = $clog2(WIDTH);
    localparam int GRP  = (SA_W + PIPE - 1) / PIPE;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SA_W-1:0]  sa;
        logic [2:0]       mode;
        logic             sign;
        logic             carry;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t stage_q [PIPE];
    stage_t stage_d [PIPE];
    logic   zero_q;
    logic   adv;

    // One shift level by s; carry is the last bit leaving the word at this level.
    function automatic logic [WIDTH:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       mode,
                                                   input logic             sign,
                                                   input int               s);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] cbits;
        logic [WIDTH-1:0] fill;
        r     = d;
        cbits = '0;
        fill  = ~({WIDTH{1'b1}} >> s);
        case (mode)
            MODE_SLL: begin
                r     = d << s;
                cbits = d >> (WIDTH - s);
            end
            MODE_SRL: begin
                r     = d >> s;
                cbits = d >> (s - 1);
            end
            MODE_SRA: begin
                r     = (d >> s) | (sign ? fill : '0);
                cbits = d >> (s - 1);
            end
            MODE_ROL: begin
                r     = (d << s) | (d >> (WIDTH - s));
                cbits = d >> (WIDTH - s);
            end
            MODE_ROR: begin
                r     = (d >> s) | (d << (WIDTH - s));
                cbits = d >> (s - 1);
            end
            default: begin
                r     = d;
                cbits = '0;
            end
        endcase
        return {r, cbits[0]};
    endfunction

    assign adv          = !stage_q[PIPE-1].valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar p = 0; p < PIPE; p++) begin : g_stage
        stage_t src;
        stage_t cur;

        if (p == 0) begin : g_entry
            always_comb begin
                src         = '0;
                src.valid   = bus.in_valid;
                src.data    = bus.in_data;
                src.sa      = bus.in_sa;
                src.mode    = bus.in_mode;
                src.sign    = bus.in_data[WIDTH-1];
                src.carry   = 1'b0;
                src.illegal = (bus.in_mode > MODE_ROR);
                src.tag     = bus.in_tag;
            end
        end else begin : g_chain
            assign src = stage_q[p-1];
        end

        // Apply only the levels owned by this stage's group.
        always_comb begin
            cur = src;
            for (int k = 0; k < SA_W; k++) begin
                if (k >= p * GRP && k < (p + 1) * GRP && !cur.illegal &&
                    ((cur.sa >> k) & SA_W'(1)) != '0) begin
                    {cur.data, cur.carry} = shift_level(cur.data, cur.mode, cur.sign, 1 << k);
                end
            end
            stage_d[p] = cur;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q[p] <= '0;
            end else if (adv) begin
                stage_q[p] <= stage_d[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (adv) begin
            zero_q <= (stage_d[PIPE-1].data == '0);
        end
    end

    assign bus.out_valid   = stage_q[PIPE-1].valid;
    assign bus.out_data    = stage_q[PIPE-1].data;
    assign bus.out_carry   = stage_q[PIPE-1].carry;
    assign bus.out_zero    = zero_q;
    assign bus.out_illegal = stage_q[PIPE-1].illegal;
    assign bus.out_tag     = stage_q[PIPE-1].tag;
endmodule
